// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// the canonical NOP and address alignment.
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one request at a time to
// instruction memory and captures responses into the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4
);

  fetch_state_t state, state_next;

  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;

  logic req_fire;
  logic load_resp;
  logic park_resp;
  logic load_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Redirect outranks stall and response; DRAIN swallows exactly one response.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        if (!redirect_valid && imem_req_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid) state_next = imem_resp_valid ? ST_REQ : ST_DRAIN;
        else if (imem_resp_valid) state_next = stall ? ST_HOLD : ST_REQ;
      end
      ST_HOLD: begin
        if (redirect_valid || !stall) state_next = ST_REQ;
      end
      ST_DRAIN: begin
        if (imem_resp_valid) state_next = ST_REQ;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == ST_REQ) && !redirect_valid;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    load_resp      = (state == ST_WAIT) && imem_resp_valid && !stall && !redirect_valid;
    park_resp      = (state == ST_WAIT) && imem_resp_valid && stall && !redirect_valid;
    load_buf       = (state == ST_HOLD) && !stall && !redirect_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc <= align_pc(redirect_pc);
    end else if (req_fire) begin
      inflight_pc <= pc;
      pc          <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_inst <= '0;
      buf_pc   <= '0;
    end else if (park_resp) begin
      buf_inst <= imem_resp_data;
      buf_pc   <= inflight_pc;
    end
  end

  // Flushing keeps the pc fields; only valid/inst are cleared to a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid    <= 1'b0;
      ifid_inst     <= INST_NOP;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
    end else if (redirect_valid) begin
      ifid_valid <= 1'b0;
      ifid_inst  <= INST_NOP;
    end else if (load_resp) begin
      ifid_valid    <= 1'b1;
      ifid_inst     <= imem_resp_data;
      ifid_pc       <= inflight_pc;
      ifid_pc_plus4 <= inflight_pc + 32'd4;
    end else if (load_buf) begin
      ifid_valid    <= 1'b1;
      ifid_inst     <= buf_inst;
      ifid_pc       <= buf_pc;
      ifid_pc_plus4 <= buf_pc + 32'd4;
    end else if (!stall) begin
      ifid_valid <= 1'b0;
      ifid_inst  <= INST_NOP;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level model plus directed scenarios
// covering streaming, stall hold, redirects, PC wrap and backpressure.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_inst      (ifid_inst),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h0000_0297;
      default:       return {a[23:0], 8'h13};
    endcase
  endfunction

  // Memory: answers each accepted request after mem_lat cycles.
  int unsigned mem_lat = 1;
  int unsigned mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  always @(posedge clk) begin
    if (rst) begin
      mem_cnt = 0;
    end else if (imem_req_valid && imem_req_ready) begin
      mem_cnt  = mem_lat;
      mem_addr = imem_req_addr;
    end
    #2;
    imem_resp_valid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = word_at(mem_addr);
      end
    end
  end

  // Reference model: outstanding request / parked word / stale flag.
  bit          m_started, m_out, m_stale, m_held, fire, loaded;
  logic [31:0] m_pc, m_out_pc, m_held_inst, m_held_pc;
  logic        e_valid;
  logic [31:0] e_inst, e_pc, e_pc4;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started = 0; m_out = 0; m_stale = 0; m_held = 0;
      m_pc = RPC; m_out_pc = '0; m_held_inst = '0; m_held_pc = '0;
      e_valid = 1'b0; e_inst = NOP; e_pc = '0; e_pc4 = '0;
    end else begin
      fire = m_started && !m_out && !m_held && !redirect_valid && imem_req_ready;
      if (redirect_valid) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        e_valid = 1'b0; e_inst = NOP;
        m_held = 0; m_started = 1;
        if (m_out) begin
          if (imem_resp_valid) m_out = 0;
          else m_stale = 1;
        end
      end else if (!m_started) begin
        m_started = 1;
        if (!stall) begin e_valid = 1'b0; e_inst = NOP; end
      end else begin
        loaded = 0;
        if (m_out && imem_resp_valid) begin
          m_out = 0;
          if (!m_stale) begin
            if (stall) begin
              m_held = 1; m_held_inst = imem_resp_data; m_held_pc = m_out_pc;
            end else begin
              loaded = 1; e_valid = 1'b1; e_inst = imem_resp_data;
              e_pc = m_out_pc; e_pc4 = m_out_pc + 32'd4;
            end
          end
          m_stale = 0;
        end else if (m_held && !stall) begin
          loaded = 1; m_held = 0; e_valid = 1'b1; e_inst = m_held_inst;
          e_pc = m_held_pc; e_pc4 = m_held_pc + 32'd4;
        end
        if (fire) begin
          m_out = 1; m_stale = 0; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
        end
        if (!loaded && !stall) begin e_valid = 1'b0; e_inst = NOP; end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_valid", {31'd0, imem_req_valid},
          {31'd0, m_started && !m_out && !m_held && !redirect_valid});
      chk("req_addr", imem_req_addr, m_pc);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e_valid});
      chk("ifid_inst", ifid_inst, e_inst);
      chk("ifid_pc", ifid_pc, e_pc);
      chk("ifid_pc_plus4", ifid_pc_plus4, e_pc4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_values();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
    chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_ifid_inst", ifid_inst, 32'h0000_0013);
    chk("rst_ifid_pc", ifid_pc, 32'h0000_0000);
    chk("rst_ifid_pc4", ifid_pc_plus4, 32'h0000_0000);
  endtask

  initial begin
    repeat (2) tick();
    #3; chk_reset_values();
    tick(); rst = 1'b0;

    // Zero-wait streaming of the first two words
    tick(); tick();
    tick(); #3;
    chk("s1_valid", {31'd0, ifid_valid}, 32'd1);
    chk("s1_inst", ifid_inst, 32'h0050_0093);
    chk("s1_pc", ifid_pc, 32'h0000_0000);
    chk("s1_pc4", ifid_pc_plus4, 32'h0000_0004);
    tick(); #3;
    chk("s1_bubble", {31'd0, ifid_valid}, 32'd0);
    tick(); #3;
    chk("s2_inst", ifid_inst, 32'h00A0_0113);
    chk("s2_pc", ifid_pc, 32'h0000_0004);
    chk("s2_pc4", ifid_pc_plus4, 32'h0000_0008);

    // Response lands while stalled, released three cycles later
    tick(); stall = 1'b1;
    tick(); #3;
    chk("hold_valid", {31'd0, ifid_valid}, 32'd0);
    chk("hold_pc", ifid_pc, 32'h0000_0004);
    chk("hold_noreq", {31'd0, imem_req_valid}, 32'd0);
    tick(); tick(); stall = 1'b0;
    tick(); #3;
    chk("unhold_inst", ifid_inst, 32'h0000_0297);
    chk("unhold_pc", ifid_pc, 32'h0000_0008);
    chk("unhold_pc4", ifid_pc_plus4, 32'h0000_000C);

    // Redirect in WAIT, stale response arrives the cycle after
    mem_lat = 2;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick(); redirect_valid = 1'b0; mem_lat = 1; #3;
    chk("drain_valid", {31'd0, ifid_valid}, 32'd0);
    chk("drain_inst", ifid_inst, 32'h0000_0013);
    chk("drain_noreq", {31'd0, imem_req_valid}, 32'd0);
    tick(); #3;
    chk("redir_addr", imem_req_addr, 32'h0000_0100);
    tick(); tick(); #3;
    chk("redir_inst", ifid_inst, 32'h0001_0013);
    chk("redir_pc", ifid_pc, 32'h0000_0100);

    // Redirect coincident with the response
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick(); redirect_valid = 1'b0; #3;
    chk("same_req", {31'd0, imem_req_valid}, 32'd1);
    chk("same_addr", imem_req_addr, 32'h0000_0200);
    chk("same_valid", {31'd0, ifid_valid}, 32'd0);
    tick(); tick(); #3;
    chk("same_inst", ifid_inst, 32'h0002_0013);
    stall = 1'b1;

    // Redirect while stalled and holding a parked word
    tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #3;
    chk("stl_valid", {31'd0, ifid_valid}, 32'd1);
    chk("stl_pc", ifid_pc, 32'h0000_0200);
    tick(); redirect_valid = 1'b0; stall = 1'b0; #3;
    chk("flush_valid", {31'd0, ifid_valid}, 32'd0);
    chk("flush_inst", ifid_inst, 32'h0000_0013);
    chk("flush_addr", imem_req_addr, 32'hFFFF_FFFC);

    // PC wrap, then request backpressure
    tick();
    tick(); imem_req_ready = 1'b0; #3;
    chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", ifid_pc_plus4, 32'h0000_0000);
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    for (int i = 0; i < 5; i++) begin
      tick(); #3;
      chk("bp_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("bp_addr", imem_req_addr, 32'h0000_0000);
    end
    imem_req_ready = 1'b1;
    tick(); tick(); #3;
    chk("bp_inst", ifid_inst, 32'h0050_0093);

    // Reset asserted with a request in flight
    tick(); #1; rst = 1'b1; #1;
    chk_reset_values();
    tick(); tick(); rst = 1'b0;
    tick(); tick(); tick(); #3;
    chk("rerun_valid", {31'd0, ifid_valid}, 32'd1);
    chk("rerun_pc", ifid_pc, 32'h0000_0000);
    chk("rerun_inst", ifid_inst, 32'h0050_0093);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage with integrated IF/ID pipeline register. It owns the program counter, issues one word-aligned request at a time to instruction memory over a valid/ready request channel, and captures each response into the IF/ID register that feeds decode and immediate generation. It honours a hazard-unit stall and an execute-stage redirect (branch/jump), discarding stale responses after a redirect.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  fetch address, always [1:0]=0.
- imem_resp_valid  in  1  response data valid; never asserted in the same cycle as its request's acceptance; always accepted.
- imem_resp_data  in  32  instruction word.
- stall  in  1  hold IF/ID contents.
- redirect_valid  in  1  flush and redirect fetch.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_inst  out  32  instruction to decode; NOP 32'h0000_0013 when invalid.
- ifid_pc  out  32  address of ifid_inst.
- ifid_pc_plus4  out  32  ifid_pc + 4, modulo 2^32.

## Operation
- Registers: pc (next address to request), inflight_pc, buffer (inst+pc), FSM state, IF/ID outputs.
- States: IDLE, REQ, WAIT, HOLD, DRAIN. Reset state IDLE; IDLE -> REQ unconditionally.
- imem_req_valid = (state==REQ) && !redirect_valid; imem_req_addr = pc.
- REQ: on accept, inflight_pc <= pc, pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0), -> WAIT.
- WAIT, resp_valid, !stall: IF/ID <= {1, resp_data, inflight_pc}, -> REQ.
- WAIT, resp_valid, stall: buffer <= {resp_data, inflight_pc}, IF/ID held, -> HOLD.
- HOLD, !stall: IF/ID <= buffer, valid=1, -> REQ. HOLD, stall: stay.
- IF/ID when not stalled and nothing loaded: valid=0, inst=NOP, pc fields unchanged.
- Stall holds all IF/ID outputs unchanged; it does not block issuing a request in REQ.
- Redirect (priority over stall and response, any state except IDLE): pc <= {redirect_pc[31:2],2'b00}; IF/ID <= invalid/NOP; buffer dropped.
  - from REQ: stay REQ (no request issued that cycle).
  - from WAIT without resp_valid: -> DRAIN. With resp_valid same cycle: response discarded, -> REQ.
  - from HOLD: -> REQ.
  - from DRAIN: stay DRAIN, pc updated.
- DRAIN: next resp_valid discarded, -> REQ (unless redirect same cycle: response still discarded, -> REQ with new pc).
- Redirect in IDLE: pc updated, -> REQ.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, ifid_valid 0, ifid_inst 32'h0000_0013, ifid_pc 0, ifid_pc_plus4 0, pc RESET_PC.
- Reset asserted mid-transaction: everything returns to reset values immediately; a late response after reset release is impossible by system contract.
- First request visible cycle 1 after reset release.
- Latency: response in cycle N -> ifid_valid visible cycle N+1.
- Zero-wait memory throughput: one instruction per 2 cycles (REQ, WAIT).
- Redirect in cycle N -> IF/ID invalid at N+1; request to target at N+1 earliest.
- At most one outstanding request at all times.

## Structure
- riscv_def.sv gains: fetch state enum (IDLE, REQ, WAIT, HOLD, DRAIN), INST_NOP = 32'h0000_0013.
- Single module; no sub-module required (buffer is one register pair).

## Test plan
- Reset, req_ready=1, one-cycle response latency, words 0x00500093, 0x00A00113 -> ifid_pc 0x0 then 0x4, inst matches, ifid_valid pulses every 2 cycles, ifid_pc_plus4 = pc+4.
- Stall held 3 cycles while response 0x00000297 arrives -> IF/ID unchanged, state HOLD, word appears cycle after stall drops.
- Redirect to 0x0000_0103 while WAIT, response arrives next cycle -> response discarded, next request addr 0x0000_0100, IF/ID NOP/invalid.
- Redirect same cycle as resp_valid -> response discarded, next request to target, no DRAIN.
- Redirect while stall=1 -> flush wins: ifid_valid 0, inst 0x00000013.
- redirect_pc 0xFFFF_FFFC, two fetches -> second addr 0x0000_0000; req_ready low 5 cycles -> req_valid and addr stable.
